// File: rtl/hack_mem_pkg.sv
// Hack data-memory map: region constants, decode helper and screen-update entry type.
// Pure definitions, no timing or flow control.
package hack_mem_pkg;

    localparam int DATA_W     = 16;
    localparam int SCR_ADDR_W = 13;

    localparam logic [14:0] RAM_BASE = 15'h0000;
    localparam logic [14:0] SCR_BASE = 15'h4000;
    localparam logic [14:0] KBD_ADDR = 15'h6000;

    typedef enum logic [1:0] {
        REG_RAM,
        REG_SCR,
        REG_KBD,
        REG_NONE
    } region_e;

    typedef struct packed {
        logic [SCR_ADDR_W-1:0] addr;
        logic [DATA_W-1:0]     data;
    } scr_upd_t;

    function automatic region_e decode_region(input logic [14:0] addr);
        region_e r;
        if (addr[14] == RAM_BASE[14]) begin
            r = REG_RAM;
        end else if (addr[14:13] == SCR_BASE[14:13]) begin
            r = REG_SCR;
        end else if (addr == KBD_ADDR) begin
            r = REG_KBD;
        end else begin
            r = REG_NONE;
        end
        return r;
    endfunction

endpackage

// File: rtl/hack_scr_fifo.sv
// Show-ahead synchronous FIFO: push lands one edge later, no bypass; pop on vld&rdy.
// Full without a same-cycle pop refuses the push and flags it on o_push_drop.
module hack_scr_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 29
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push_vld,
    input  logic [WIDTH-1:0] i_push_dat,
    output logic             o_push_drop,
    output logic             o_head_vld,
    output logic [WIDTH-1:0] o_head_dat,
    input  logic             i_head_rdy
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    logic w_full;
    logic w_pop;
    logic w_push;

    assign w_full      = (r_count == CW'(DEPTH));
    assign o_head_vld  = (r_count != '0);
    assign o_head_dat  = r_mem[r_rd_ptr];
    assign w_pop       = o_head_vld & i_head_rdy;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_push      = i_push_vld & (~w_full | w_pop);
    assign o_push_drop = i_push_vld & ~w_push;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_dat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/hack_data_memory.sv
// Hack data memory (RAM, screen, keyboard): zero-latency reads, writes on the edge.
// Screen writes feed a show-ahead FIFO; when it is full the update is dropped and counted.
module hack_data_memory
    import hack_mem_pkg::*;
#(
    parameter int RAM_WORDS  = 16384,
    parameter int SCR_WORDS  = 8192,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [15:0]           addressM,
    input  logic [DATA_W-1:0]     outM,
    input  logic                  wen,
    output logic [DATA_W-1:0]     inM,
    input  logic                  kbd_strobe,
    input  logic [DATA_W-1:0]     kbd_code,
    output logic                  scr_valid,
    output logic [SCR_ADDR_W-1:0] scr_addr,
    output logic [DATA_W-1:0]     scr_data,
    input  logic                  scr_ready,
    output logic                  scr_overflow,
    output logic [7:0]            drop_count
);
    localparam int RAM_AW = $clog2(RAM_WORDS);
    localparam int SCR_AW = $clog2(SCR_WORDS);

    logic [DATA_W-1:0] r_ram [RAM_WORDS];
    logic [DATA_W-1:0] r_scr [SCR_WORDS];
    logic [DATA_W-1:0] r_kbd;
    logic              r_overflow;
    logic [7:0]        r_drop_count;

    logic [14:0]       w_a;
    region_e           w_region;
    logic [RAM_AW-1:0] w_ram_idx;
    logic [SCR_AW-1:0] w_scr_idx;
    logic              w_ram_wr;
    logic              w_scr_wr;
    logic              w_kbd_wr;
    logic              w_drop;
    scr_upd_t          w_push_dat;
    scr_upd_t          w_head_dat;
    logic              w_unused;

    // Bit 15 of the CPU address has no meaning in the data map.
    assign w_unused  = addressM[15];
    assign w_a       = addressM[14:0];
    assign w_region  = decode_region(w_a);
    assign w_ram_idx = w_a[RAM_AW-1:0];
    assign w_scr_idx = w_a[SCR_AW-1:0];

    assign w_ram_wr = wen & (w_region == REG_RAM);
    assign w_scr_wr = wen & (w_region == REG_SCR);
    assign w_kbd_wr = wen & (w_region == REG_KBD);

    always_comb begin
        inM = '0;
        case (w_region)
            REG_RAM: inM = r_ram[w_ram_idx];
            REG_SCR: inM = r_scr[w_scr_idx];
            REG_KBD: inM = r_kbd;
            default: inM = '0;
        endcase
    end

    // Arrays are deliberately outside reset so their contents survive it.
    always_ff @(posedge clk) begin
        if (w_ram_wr) begin
            r_ram[w_ram_idx] <= outM;
        end
        if (w_scr_wr) begin
            r_scr[w_scr_idx] <= outM;
        end
    end

    assign w_push_dat.addr = w_a[SCR_ADDR_W-1:0];
    assign w_push_dat.data = outM;

    hack_scr_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(scr_upd_t))
    ) u_scr_fifo (
        .clk         (clk),
        .rst_n       (reset),
        .i_push_vld  (w_scr_wr),
        .i_push_dat  (w_push_dat),
        .o_push_drop (w_drop),
        .o_head_vld  (scr_valid),
        .o_head_dat  (w_head_dat),
        .i_head_rdy  (scr_ready)
    );

    assign scr_addr = w_head_dat.addr;
    assign scr_data = w_head_dat.data;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_kbd        <= '0;
            r_overflow   <= 1'b0;
            r_drop_count <= '0;
        end else begin
            // A fresh key code outranks the CPU acknowledge in the same cycle.
            if (kbd_strobe) begin
                r_kbd <= kbd_code;
            end else if (w_kbd_wr) begin
                r_kbd <= '0;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_count != 8'hFF) begin
                    r_drop_count <= r_drop_count + 8'd1;
                end
            end
        end
    end

    assign scr_overflow = r_overflow;
    assign drop_count   = r_drop_count;

endmodule

// File: tb/tb_hack_data_memory.sv
// Bench for hack_data_memory: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a queue/array model.
module tb_hack_data_memory;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] addressM = 16'h0;
    logic [15:0] outM = 16'h0;
    logic        wen = 1'b0;
    logic [15:0] inM;
    logic        kbd_strobe = 1'b0;
    logic [15:0] kbd_code = 16'h0;
    logic        scr_valid;
    logic [12:0] scr_addr;
    logic [15:0] scr_data;
    logic        scr_ready = 1'b0;
    logic        scr_overflow;
    logic [7:0]  drop_count;

    hack_data_memory #(
        .RAM_WORDS  (16384),
        .SCR_WORDS  (8192),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .addressM     (addressM),
        .outM         (outM),
        .wen          (wen),
        .inM          (inM),
        .kbd_strobe   (kbd_strobe),
        .kbd_code     (kbd_code),
        .scr_valid    (scr_valid),
        .scr_addr     (scr_addr),
        .scr_data     (scr_data),
        .scr_ready    (scr_ready),
        .scr_overflow (scr_overflow),
        .drop_count   (drop_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [15:0] m_ram [16384];
    bit          m_ram_w [16384];
    logic [15:0] m_scr [8192];
    bit          m_scr_w [8192];
    logic [15:0] m_kbd;
    logic [28:0] m_q [$];
    bit          m_ovf;
    int          m_drops;

    // 0 = RAM, 1 = screen, 2 = keyboard, 3 = unmapped
    function automatic int region(input logic [15:0] adr);
        int a;
        a = int'(adr & 16'h7FFF);
        if (a < 'h4000) return 0;
        if (a < 'h6000) return 1;
        if (a == 'h6000) return 2;
        return 3;
    endfunction

    always @(posedge clk or negedge reset) begin
        int a;
        int idx;
        if (!reset) begin
            m_kbd   = 16'h0;
            m_q.delete();
            m_ovf   = 1'b0;
            m_drops = 0;
        end else begin
            a = int'(addressM & 16'h7FFF);
            if (m_q.size() != 0 && scr_ready) void'(m_q.pop_front());
            if (wen) begin
                case (region(addressM))
                    0: begin m_ram[a] = outM; m_ram_w[a] = 1'b1; end
                    1: begin
                        idx = a - 'h4000;
                        m_scr[idx] = outM;
                        m_scr_w[idx] = 1'b1;
                        if (m_q.size() < DEPTH) begin
                            m_q.push_back({idx[12:0], outM});
                        end else begin
                            m_ovf = 1'b1;
                            if (m_drops < 255) m_drops++;
                        end
                    end
                    2: m_kbd = 16'h0;
                    default: ;
                endcase
            end
            if (kbd_strobe) m_kbd = kbd_code;
        end
    end

    always @(negedge clk) begin
        int a;
        if (reset) begin
            a = int'(addressM & 16'h7FFF);
            case (region(addressM))
                0: if (m_ram_w[a]) check("inM_ram", inM, m_ram[a]);
                1: if (m_scr_w[a - 'h4000]) check("inM_scr", inM, m_scr[a - 'h4000]);
                2: check("inM_kbd", inM, m_kbd);
                default: check("inM_none", inM, 32'h0);
            endcase
            check("scr_valid", scr_valid, (m_q.size() != 0) ? 32'd1 : 32'd0);
            if (m_q.size() != 0) begin
                check("scr_addr", scr_addr, m_q[0][28:16]);
                check("scr_data", scr_data, m_q[0][15:0]);
            end
            check("scr_overflow", scr_overflow, m_ovf);
            check("drop_count", drop_count, m_drops);
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        addressM = a;
        outM     = d;
        wen      = 1'b1;
        cyc();
        wen      = 1'b0;
    endtask

    initial begin
        logic [15:0] exp_d [4];
        logic [12:0] exp_a [4];
        exp_d = '{16'h0011, 16'h0012, 16'h0013, 16'hAAAA};
        exp_a = '{13'h0011, 13'h0012, 13'h0013, 13'h0100};

        #1 reset = 1'b0;
        #12;
        check("rst_valid", scr_valid, 32'd0);
        check("rst_ovf", scr_overflow, 32'd0);
        check("rst_drop", drop_count, 32'd0);
        addressM = 16'h6000;
        #1 check("rst_kbd", inM, 32'h0);
        @(posedge clk);
        #1 reset = 1'b1;

        // RAM write/read, unmapped read, bit 15 alias
        wr(16'h0010, 16'h1234);
        addressM = 16'h0010;
        #1 check("ram_rd", inM, 32'h1234);
        addressM = 16'h6001;
        #1 check("none_rd", inM, 32'h0);
        addressM = 16'h8010;
        #1 check("ram_bit15", inM, 32'h1234);

        // single screen write, popped on the following edge
        scr_ready = 1'b1;
        wr(16'h4005, 16'hFFFF);
        check("scr1_valid", scr_valid, 32'd1);
        check("scr1_addr", scr_addr, 32'h0005);
        check("scr1_data", scr_data, 32'hFFFF);
        cyc();
        check("scr1_empty", scr_valid, 32'd0);
        addressM = 16'h4005;
        #1 check("scr1_rd", inM, 32'hFFFF);

        // overflow on the fifth write with the display stalled
        scr_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            wr(16'h4000 + 16'(i), 16'(i + 1));
            if (i == 3) check("ovf_before", scr_overflow, 32'd0);
        end
        check("ovf_set", scr_overflow, 32'd1);
        check("drop_one", drop_count, 32'd1);
        addressM = 16'h4004;
        #1 check("scr_dropped_ram", inM, 32'h0005);
        scr_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("drain_data", scr_data, 32'(i + 1));
            cyc();
        end
        check("drain_empty", scr_valid, 32'd0);

        // push while full with a simultaneous pop is accepted
        scr_ready = 1'b0;
        for (int i = 0; i < 4; i++) wr(16'h4010 + 16'(i), 16'h0010 + 16'(i));
        scr_ready = 1'b1;
        wr(16'h4100, 16'hAAAA);
        check("full_pp_drop", drop_count, 32'd1);
        check("full_pp_head", scr_data, 32'h0011);
        scr_ready = 1'b0;
        wr(16'h4020, 16'hBEEF);
        check("full_pp_cnt4", drop_count, 32'd2);
        scr_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("pp_drain_addr", scr_addr, exp_a[i]);
            check("pp_drain_data", scr_data, exp_d[i]);
            cyc();
        end
        check("pp_drain_empty", scr_valid, 32'd0);

        // keyboard load, acknowledge, and strobe-wins collision
        kbd_code = 16'h0041;
        kbd_strobe = 1'b1;
        cyc();
        kbd_strobe = 1'b0;
        addressM = 16'h6000;
        #1 check("kbd_load", inM, 32'h0041);
        wr(16'h6000, 16'h1234);
        #1 check("kbd_ack", inM, 32'h0);
        kbd_code = 16'h0042;
        kbd_strobe = 1'b1;
        wr(16'h6000, 16'h9999);
        kbd_strobe = 1'b0;
        #1 check("kbd_collide", inM, 32'h0042);

        // asynchronous reset with entries pending
        scr_ready = 1'b0;
        wr(16'h4030, 16'h0001);
        wr(16'h4031, 16'h0002);
        wr(16'h4032, 16'h0003);
        check("pre_rst_valid", scr_valid, 32'd1);
        #2 reset = 1'b0;
        #1;
        check("arst_valid", scr_valid, 32'd0);
        check("arst_ovf", scr_overflow, 32'd0);
        check("arst_drop", drop_count, 32'd0);
        #3 reset = 1'b1;
        addressM = 16'h0010;
        #1 check("ram_kept", inM, 32'h1234);
        cyc();

        // randomized traffic
        repeat (3000) begin
            logic [15:0] a;
            case ($urandom_range(0, 3))
                0:       a = 16'($urandom_range(0, 63));
                1:       a = 16'h4000 + 16'($urandom_range(0, 63));
                2:       a = 16'h6000;
                default: a = 16'($urandom_range(16'h6001, 16'h7FFF));
            endcase
            if ($urandom_range(0, 3) == 0) a[15] = 1'b1;
            addressM   = a;
            outM       = 16'($urandom);
            wen        = ($urandom_range(0, 1) == 1);
            kbd_strobe = ($urandom_range(0, 9) == 0);
            kbd_code   = 16'($urandom);
            scr_ready  = ($urandom_range(0, 9) < 4);
            cyc();
        end
        wen = 1'b0;
        kbd_strobe = 1'b0;

        // drop counter saturation
        scr_ready = 1'b0;
        for (int i = 0; i < 260; i++) wr(16'h4200 + 16'(i), 16'(i));
        check("drop_sat", drop_count, 32'd255);
        check("ovf_sticky", scr_overflow, 32'd1);
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
